// File: rtl/norm_pipe.sv
// Two-stage per-lane normaliser: out = sat(((x - mean) * inv_var) >>> SHIFT),
// with ready/valid backpressure, a row counter driving done_norm, and a combinational bypass.

module norm_lane #(
    parameter int DWIDTH = 8,
    parameter int SHIFT  = 4
) (
    input  logic [DWIDTH-1:0] i_x,
    input  logic [DWIDTH-1:0] i_mean,
    output logic [DWIDTH:0]   o_diff,
    input  logic [DWIDTH:0]   i_diff,
    input  logic [DWIDTH-1:0] i_inv_var,
    output logic [DWIDTH-1:0] o_q
);
    localparam int PW = 2*DWIDTH + 2;
    localparam logic signed [PW-1:0] MAXV = {{(DWIDTH+3){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(DWIDTH+3){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;

    // Both operands widened to a common width so the signed multiply cannot overflow.
    assign o_diff  = {i_x[DWIDTH-1], i_x} - {i_mean[DWIDTH-1], i_mean};
    assign w_prod  = $signed({{(DWIDTH+1){i_diff[DWIDTH]}}, i_diff})
                   * $signed({{(DWIDTH+2){1'b0}}, i_inv_var});
    assign w_shift = w_prod >>> SHIFT;

    always_comb begin
        o_q = w_shift[DWIDTH-1:0];
        if (w_shift > MAXV)
            o_q = MAXV[DWIDTH-1:0];
        else if (w_shift < MINV)
            o_q = MINV[DWIDTH-1:0];
    end
endmodule

module norm_pipe #(
    parameter int DWIDTH   = 8,
    parameter int LANES    = 4,
    parameter int NUM_ROWS = 4,
    parameter int SHIFT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_norm,
    input  logic                    clear,
    input  logic [DWIDTH-1:0]       mean,
    input  logic [DWIDTH-1:0]       inv_var,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DWIDTH-1:0] inp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DWIDTH-1:0] out_data,
    output logic                    done_norm,
    output logic                    busy
);
    localparam int CW = $clog2(NUM_ROWS + 1);

    logic [2:1]                       r_vld_pipe;
    logic [LANES-1:0][DWIDTH:0]       r_diff;
    logic [DWIDTH-1:0]                r_inv;
    logic [LANES-1:0][DWIDTH-1:0]     r_out;
    logic [CW-1:0]                    r_row_cnt;
    logic                             r_done;

    logic [LANES-1:0][DWIDTH-1:0]     w_x;
    logic [LANES-1:0][DWIDTH:0]       w_diff;
    logic [LANES-1:0][DWIDTH-1:0]     w_q;
    logic                             w_adv1, w_adv2, w_out_hs;

    assign w_x      = inp_data;
    assign w_adv2   = ~r_vld_pipe[2] | out_ready;
    assign w_adv1   = ~r_vld_pipe[1] | w_adv2;
    assign w_out_hs = enable_norm & r_vld_pipe[2] & out_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        norm_lane #(.DWIDTH(DWIDTH), .SHIFT(SHIFT)) u_lane (
            .i_x      (w_x[g]),
            .i_mean   (mean),
            .o_diff   (w_diff[g]),
            .i_diff   (r_diff[g]),
            .i_inv_var(r_inv),
            .o_q      (w_q[g])
        );
    end

    // Pipeline freezes entirely while bypassed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_diff     <= '0;
            r_inv      <= '0;
            r_out      <= '0;
        end else if (enable_norm) begin
            if (w_adv1) begin
                r_vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    r_diff <= w_diff;
                    r_inv  <= inv_var;
                end
            end
            if (w_adv2) begin
                r_vld_pipe[2] <= r_vld_pipe[1];
                if (r_vld_pipe[1])
                    r_out <= w_q;
            end
        end
    end

    // clear has priority over a coincident output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_cnt <= '0;
            r_done    <= 1'b0;
        end else if (clear) begin
            r_row_cnt <= '0;
            r_done    <= 1'b0;
        end else if (w_out_hs) begin
            if (r_row_cnt == CW'(NUM_ROWS - 1)) begin
                r_row_cnt <= '0;
                r_done    <= 1'b1;
            end else begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = enable_norm ? w_adv1        : out_ready;
    assign out_valid = enable_norm ? r_vld_pipe[2] : in_valid;
    assign out_data  = enable_norm ? r_out         : inp_data;
    assign done_norm = enable_norm ? r_done        : 1'b1;
    assign busy      = |r_vld_pipe;
endmodule

// File: tb/tb_norm_pipe.sv
// Directed bench for norm_pipe: arithmetic, saturation, backpressure, row counting, clear, bypass, reset.

module tb_norm_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_norm = 1'b1;
    logic        clear = 1'b0;
    logic [7:0]  mean = '0;
    logic [7:0]  inv_var = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        done_norm;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] beats [4];

    norm_pipe #(.DWIDTH(8), .LANES(4), .NUM_ROWS(4), .SHIFT(4)) dut (
        .clk(clk), .reset(reset), .enable_norm(enable_norm), .clear(clear),
        .mean(mean), .inv_var(inv_var), .in_valid(in_valid), .in_ready(in_ready),
        .inp_data(inp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .done_norm(done_norm), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mean=0, inv_var=16 makes the normaliser an identity for small positive lanes.
    task automatic send_identity(input int n);
        mean = 8'd0; inv_var = 8'd16; out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; inp_data = beats[i % 4];
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done_norm !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_norm); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        mean = 8'd2; inv_var = 8'd32; inp_data = {4{8'd10}}; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1: got out_valid %b expected 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_lat2: got out_valid %b expected 1", out_valid); end
        tests++; if (out_data !== 32'h10101010) begin fails++; $display("FAIL basic_data: got %h expected 10101010", out_data); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        mean = 8'h80; inv_var = 8'd255; inp_data = {4{8'h7f}}; in_valid = 1'b1;
        tick();
        mean = 8'd100; inv_var = 8'd255; inp_data = {4{8'h9c}};
        tick();
        tests++; if (out_data !== 32'h7f7f7f7f || out_valid !== 1'b1) begin fails++; $display("FAIL sat_pos: got %h/%b expected 7f7f7f7f/1", out_data, out_valid); end
        mean = 8'd1; inv_var = 8'd8; inp_data = 32'h0;
        tick();
        in_valid = 1'b0;
        tests++; if (out_data !== 32'h80808080 || out_valid !== 1'b1) begin fails++; $display("FAIL sat_neg: got %h/%b expected 80808080/1", out_data, out_valid); end
        tick();
        tests++; if (out_data !== 32'hffffffff || out_valid !== 1'b1) begin fails++; $display("FAIL floor_neg: got %h/%b expected ffffffff/1", out_data, out_valid); end
        tick();
        tests++; if (done_norm !== 1'b1) begin fails++; $display("FAIL done_after4: got %b expected 1", done_norm); end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++; if (done_norm !== 1'b0) begin fails++; $display("FAIL clear_done: got %b expected 0", done_norm); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clear_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, first_out = -1;
        bit done_checked = 1'b0, stall_checked = 1'b0;
        bit hs_in, hs_out;
        logic [31:0] od;
        mean = 8'd0; inv_var = 8'd16;
        for (int c = 0; c < 30 && !done_checked; c++) begin
            in_valid = (sent < 4);
            inp_data = beats[sent < 4 ? sent : 0];
            if (first_out < 0 && out_valid) first_out = c;
            out_ready = !(first_out >= 0 && c < first_out + 3);
            #3;
            if (c == first_out) begin
                stall_checked = 1'b1;
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            end
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            od     = out_data;
            if (hs_out) begin
                tests++; if (od !== beats[got]) begin fails++; $display("FAIL stream_order%0d: got %h expected %h", got, od, beats[got]); end
                if (got == 3) begin
                    tests++; if (done_norm !== 1'b0) begin fails++; $display("FAIL done_early: got %b expected 0", done_norm); end
                end
                got++;
            end
            if (hs_in) sent++;
            tick();
            if (got == 4) begin
                done_checked = 1'b1;
                tests++; if (done_norm !== 1'b1) begin fails++; $display("FAIL done_rise: got %b expected 1", done_norm); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        if (!done_checked || !stall_checked) begin
            tests++; fails++;
            $display("FAIL stream_timeout: got %0d outputs expected 4", got);
        end
    endtask

    task automatic test_reset_mid();
        mean = 8'd0; inv_var = 8'd16; out_ready = 1'b0;
        in_valid = 1'b1; inp_data = beats[0];
        tick();
        inp_data = beats[1];
        tick();
        in_valid = 1'b0;
        tests++; if (busy !== 1'b1 || out_valid !== 1'b1 || done_norm !== 1'b1) begin fails++; $display("FAIL prereset: got busy %b valid %b done %b expected 1 1 1", busy, out_valid, done_norm); end
        #2 reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || done_norm !== 1'b0) begin fails++; $display("FAIL async_reset: got valid %b busy %b done %b expected 0 0 0", out_valid, busy, done_norm); end
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; inp_data = beats[2];
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_lat1: got %b expected 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== beats[2]) begin fails++; $display("FAIL post_reset_lat2: got %b/%h expected 1/%h", out_valid, out_data, beats[2]); end
        tick();
    endtask

    task automatic test_clear_handshake();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mean = 8'd0; inv_var = 8'd16; out_ready = 1'b1;
        in_valid = 1'b1; inp_data = beats[3];
        tick();
        in_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL clr_hs_valid: got %b expected 1", out_valid); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send_identity(3);
        tests++; if (done_norm !== 1'b0) begin fails++; $display("FAIL clr_hs_uncounted: got %b expected 0", done_norm); end
        send_identity(1);
        tests++; if (done_norm !== 1'b1) begin fails++; $display("FAIL clr_hs_reraise: got %b expected 1", done_norm); end
    endtask

    task automatic test_bypass();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable_norm = 1'b0; inp_data = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        tests++; if (out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL byp_data: got %h expected deadbeef", out_data); end
        tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || done_norm !== 1'b1) begin fails++; $display("FAIL byp_ctrl: got valid %b ready %b done %b expected 1 0 1", out_valid, in_ready, done_norm); end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL byp_ready: got %b expected 1", in_ready); end
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL byp_hold: got busy %b expected 0", busy); end
        enable_norm = 1'b1; in_valid = 1'b0;
        #1;
        tests++; if (done_norm !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL byp_exit: got done %b valid %b expected 0 0", done_norm, out_valid); end
    endtask

    initial begin
        beats[0] = 32'h04030201;
        beats[1] = 32'h14131211;
        beats[2] = 32'h24232221;
        beats[3] = 32'h34333231;
        test_reset();
        test_basic();
        test_saturation();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_clear_handshake();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
